// File: rtl/aes_cipher_sched.sv
// Round-robin scheduler sharing one AES-128 cipher core among NREQ requesters.
// Optional BUSY-state watchdog is compiled in with `define AES_SCHED_WATCHDOG_EN.
module aes_cipher_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = $clog2(NREQ),
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*128-1:0]  req_key,
  input  logic [NREQ*128-1:0]  req_text,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [127:0]         resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_err,
  output logic                 core_ld,
  output logic [127:0]         core_key,
  output logic [127:0]         core_text_in,
  input  logic                 core_done,
  input  logic [127:0]         core_text_out,
  output logic                 busy,
  output logic [15:0]          jobs_done
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("aes_cipher_sched: unsupported NREQ or TIMEOUT_CYC");
  end

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, gnt_idx;
  logic [IDW:0]   scan;
  logic           gnt_vld, wd_hit;
  logic [127:0]   key_q, text_q, data_q;
  logic [15:0]    jobs_q;

  // Scan offsets high to low so the nearest valid index at/after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (req_valid[scan[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_vld) state_d = S_LOAD;
      S_LOAD:  state_d = S_BUSY;
      S_BUSY:  if (core_done || wd_hit) state_d = S_RESP;
      default: if (resp_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      key_q   <= '0;
      text_q  <= '0;
      data_q  <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && gnt_vld) begin
        key_q  <= req_key[{gnt_idx, 7'd0} +: 128];
        text_q <= req_text[{gnt_idx, 7'd0} +: 128];
        id_q   <= gnt_idx;
        ptr_q  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // core_done beats a same-cycle watchdog expiry.
      if (state_q == S_BUSY) begin
        if (core_done)   data_q <= core_text_out;
        else if (wd_hit) data_q <= '0;
      end
      if (state_q == S_RESP && resp_ready) jobs_q <= jobs_q + 16'd1;
    end
  end

`ifdef AES_SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;

  // Counter sits at zero outside BUSY, so it restarts on every BUSY entry.
  assign wd_hit = (state_q == S_BUSY) && (wd_q == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == S_BUSY) ? wd_q + 1'b1 : '0;
      if (state_q == S_BUSY) begin
        if (core_done)   err_q <= 1'b0;
        else if (wd_hit) err_q <= 1'b1;
      end
    end
  end

  assign resp_err = err_q;
`else
  assign wd_hit   = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign resp_valid   = (state_q == S_RESP);
  assign resp_data    = data_q;
  assign resp_id      = id_q;
  assign core_ld      = (state_q == S_LOAD);
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign busy         = (state_q != S_IDLE);
  assign jobs_done    = jobs_q;
endmodule

// File: doc/aes_cipher_sched.md
# aes_cipher_sched

Round-robin scheduler that shares one AES-128 cipher core among `NREQ` requesters. It accepts one {key, plaintext} job at a time over a valid/ready handshake and drives the core's one-cycle load. It then waits for the core's completion pulse and returns the ciphertext, tagged with the requester index, over a valid/ready response channel. The block sits between the system request fabric and the cipher core instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester index.
- `TIMEOUT_CYC`, 32: watchdog limit in BUSY cycles; used only when the watchdog is compiled in.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  per-requester job valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_key`  in  NREQ*128  key; requester i uses bits [128i+127:128i].
- `req_text`  in  NREQ*128  plaintext, same packing as `req_key`.
- `resp_valid`  out  1  ciphertext available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  128  ciphertext.
- `resp_id`  out  IDW  index of the requester that owns the response.
- `resp_err`  out  1  job aborted by the watchdog.
- `core_ld`  out  1  one-cycle load strobe to the cipher core.
- `core_key`  out  128  key to the core.
- `core_text_in`  out  128  plaintext to the core.
- `core_done`  in  1  single-cycle completion pulse from the core.
- `core_text_out`  in  128  core ciphertext; valid in the `core_done` cycle.
- `busy`  out  1  state is not IDLE.
- `jobs_done`  out  16  count of completed responses; wraps at 16'hffff -> 0.

## Operation
- FSM states:
  - **IDLE**: arbitrate. When any `req_valid` is high, the grant `g` is the first index at or after `ptr`, modulo NREQ. `req_ready[g]=1` combinationally, and only in IDLE. On the grant: latch `req_key[g]`, `req_text[g]` and `g`; set `ptr <= (g+1) mod NREQ`; go to LOAD.
  - **LOAD**: `core_ld=1` for exactly one cycle. `core_key` and `core_text_in` are driven from the latched registers and held stable until the next grant. Go to BUSY.
  - **BUSY**: `core_done` is sampled only in this state. On `core_done=1`: `resp_data <= core_text_out`, `resp_err <= 0`, go to RESP.
  - **RESP**: `resp_valid=1`. On `resp_valid & resp_ready`, go to IDLE and increment `jobs_done`.
- Response channel rules:
  - `resp_data`, `resp_id` and `resp_err` stay stable while `resp_valid` is high.
  - No new grant is made until the response is accepted.
- Requesters hold `req_valid` and their data stable until they see `req_ready`.
- A requester that drops valid before being granted loses nothing; the pointer advances only on a grant.
- `core_done` outside BUSY is ignored.

## Timing
- Reset values:
  - state IDLE, `ptr=0`, `jobs_done=0`.
  - `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_id=0`, `resp_err=0`.
  - `core_ld=0`, `core_key=0`, `core_text_in=0`, `busy=0`.
- Cycle sequence, with the request accepted in cycle T:
  - `core_ld` is high in T+1.
  - BUSY starts at T+2.
  - If `core_done` is high in cycle D, `resp_valid` rises in D+1.
  - Fastest return to IDLE: the cycle after acceptance when `resp_ready` is already high.
- Minimum request-to-request spacing is the core latency plus 3 cycles.
- Reset mid-operation (`rst=0` in any state) aborts the job with no response. The core shares `rst` and is cleared too.
- A request that is valid in the same cycle as a response acceptance is not granted until the following cycle (IDLE).

## Configuration
- `AES_SCHED_WATCHDOG_EN` defined:
  - A BUSY cycle counter clears on entry to BUSY.
  - If it reaches `TIMEOUT_CYC` without `core_done`, go to RESP with `resp_err=1` and `resp_data=0`; `resp_id` is the granted index.
  - If `core_done` arrives in the same cycle the limit is reached, `core_done` wins.
- `AES_SCHED_WATCHDOG_EN` undefined:
  - No counter; `resp_err` is tied to 0.
  - BUSY waits indefinitely for `core_done`.

## Test plan
- Single job on requester 0, key `000102030405060708090a0b0c0d0e0f`, pt `00112233445566778899aabbccddeeff` -> one `core_ld` pulse; `resp_data=69c4e0d86a7b0430d8cdb78070b4c55a`, `resp_id=0`, `resp_err=0`, `jobs_done=1`.
- All 4 requesters continuously valid with distinct FIPS-197 vectors -> grant order 0,1,2,3,0,1; every ciphertext correct and matched to its `resp_id`.
- Only requesters 2 and 3 valid, `ptr=0` -> grants 2 then 3; `ptr` ends at 0.
- `resp_ready` held low for 10 cycles after `resp_valid` -> `resp_valid`, `resp_data` and `resp_id` stable; `req_ready` stays 0 throughout; the next grant comes one cycle after acceptance.
- `rst=0` for one cycle while BUSY -> next cycle all outputs at reset values, no response issued; a following job completes correctly.
- Watchdog build, stub core never asserts `core_done` -> `resp_valid` with `resp_err=1` and `resp_data=0` after 32 BUSY cycles. Non-watchdog build, same stub -> `busy` stays 1 and `resp_valid` stays 0.
